// File: rtl/pio_poll_sequencer.sv
// Periodic sweeper for a bank of Avalon-MM input PIOs; changed words from monitored
// ports are queued in a FIFO with a level interrupt. PIO_POLL_TIMESTAMP_EN adds per-entry cycle stamps.
module pio_poll_sequencer #(
  parameter int NUM_PORTS  = 4,
  parameter int PERIOD     = 1000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [1:0]              m_address,
  input  logic [32*NUM_PORTS-1:0] m_readdata,
  input  logic [2:0]              s_address,
  input  logic                    s_read,
  input  logic                    s_write,
  input  logic [31:0]             s_writedata,
  output logic [31:0]             s_readdata,
  output logic                    irq
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] RELOAD   = TW'(PERIOD - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PORTS - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, CAPT, NEXT} state_e;

  state_e         state_q;
  logic [IW-1:0]  idx_q;
  logic [TW-1:0]  timer_q;
  logic           req_q;
  logic           enable_q;
  logic           irq_en_q;
  logic           primed_q;
  logic           ovf_q;
  logic [NUM_PORTS-1:0] mask_q;
  logic [CW-1:0]  count_q;
  logic [PW-1:0]  wptr_q;
  logic [PW-1:0]  rptr_q;
  logic [31:0]    data_mem_q [FIFO_DEPTH];
  logic [2:0]     tag_mem_q  [FIFO_DEPTH];
  logic [31:0]    shadow_q   [NUM_PORTS];
  logic [1:0]     m_address_q;
  logic [31:0]    s_readdata_q;
  logic           irq_q;
`ifdef PIO_POLL_TIMESTAMP_EN
  logic [31:0]    ts_q;
  logic [31:0]    ts_mem_q [FIFO_DEPTH];
`endif

  logic [31:0]    port_data [NUM_PORTS];
  logic [31:0]    sample;
  logic           ctrl_wr;
  logic           disable_now;
  logic           enable_d;
  logic           irq_en_d;
  logic           capt_fire;
  logic           push_want;
  logic           push_ok;
  logic           pop;
  logic           tick;
  logic [CW-1:0]  count_d;
  logic           ovf_d;
  logic           irq_d;
  logic [2:0]     head_tag;
  logic [31:0]    rd_data_d;
  logic           unused_wdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) port_data[i] = m_readdata[32*i +: 32];
  end

  assign sample       = port_data[idx_q];
  assign unused_wdata = ^s_writedata;

  assign ctrl_wr     = s_write && (s_address == 3'd2);
  assign disable_now = ctrl_wr && !s_writedata[0];
  assign enable_d    = ctrl_wr ? s_writedata[0] : enable_q;
  assign irq_en_d    = ctrl_wr ? s_writedata[1] : irq_en_q;
  assign tick        = enable_q && !disable_now && (timer_q == '0);

  // A capture is abandoned if the CPU disables in the same cycle.
  assign capt_fire = (state_q == CAPT) && !disable_now;
  assign push_want = capt_fire && primed_q && mask_q[idx_q] && (sample != shadow_q[idx_q]);
  assign push_ok   = push_want && (count_q != FULL_CNT);
  assign pop       = s_read && (s_address == 3'd0) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push_ok) count_d = count_d + CW'(1);
    if (pop)     count_d = count_d - CW'(1);
    ovf_d = ovf_q;
    if (ctrl_wr && s_writedata[2]) ovf_d = 1'b0;
    if (push_want && !push_ok)     ovf_d = 1'b1;
    irq_d = irq_en_d && ((count_d != '0) || ovf_d);
  end

  assign head_tag = (count_q != '0) ? tag_mem_q[rptr_q] : 3'd0;

  always_comb begin
    rd_data_d = '0;
    case (s_address)
      3'd0: if (count_q != '0) rd_data_d = data_mem_q[rptr_q];
      3'd1: begin
        rd_data_d[31]    = ovf_q;
        rd_data_d[26:24] = head_tag;
        rd_data_d[7:0]   = 8'(count_q);
      end
      3'd2: rd_data_d[1:0] = {irq_en_q, enable_q};
      3'd3: rd_data_d[NUM_PORTS-1:0] = mask_q;
`ifdef PIO_POLL_TIMESTAMP_EN
      3'd4: if (count_q != '0) rd_data_d = ts_mem_q[rptr_q];
`endif
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      timer_q      <= RELOAD;
      req_q        <= 1'b0;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      primed_q     <= 1'b0;
      ovf_q        <= 1'b0;
      mask_q       <= '1;
      count_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      m_address_q  <= 2'd0;
      s_readdata_q <= '0;
      irq_q        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        tag_mem_q[i]  <= '0;
      end
      for (int i = 0; i < NUM_PORTS; i++) shadow_q[i] <= '0;
`ifdef PIO_POLL_TIMESTAMP_EN
      ts_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) ts_mem_q[i] <= '0;
`endif
    end else begin
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
      if (s_write && (s_address == 3'd3)) mask_q <= s_writedata[NUM_PORTS-1:0];
      if (s_read) s_readdata_q <= rd_data_d;
`ifdef PIO_POLL_TIMESTAMP_EN
      ts_q <= ts_q + 32'd1;
      if (push_ok) ts_mem_q[wptr_q] <= ts_q;
`endif
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (push_ok) begin
        data_mem_q[wptr_q] <= sample;
        tag_mem_q[wptr_q]  <= 3'(idx_q);
        wptr_q             <= ptr_inc(wptr_q);
      end

      if (disable_now) begin
        // Queued data survives a disable; the sweep and shadow priming do not.
        state_q  <= IDLE;
        idx_q    <= '0;
        req_q    <= 1'b0;
        primed_q <= 1'b0;
      end else begin
        if (enable_q) timer_q <= (timer_q == '0) ? RELOAD : timer_q - TW'(1);
        req_q <= tick || (req_q && (state_q != IDLE));
        case (state_q)
          IDLE: if (req_q) begin
            idx_q   <= '0;
            state_q <= ADDR;
          end
          ADDR: begin
            m_address_q <= 2'd0;
            state_q     <= CAPT;
          end
          CAPT: begin
            shadow_q[idx_q] <= sample;
            state_q         <= NEXT;
          end
          NEXT: if (idx_q == LAST_IDX) begin
            primed_q <= 1'b1;
            idx_q    <= '0;
            state_q  <= IDLE;
          end else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= ADDR;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign m_address  = m_address_q;
  assign s_readdata = s_readdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_pio_poll_sequencer.sv
// Directed bench for pio_poll_sequencer with PERIOD=16, four ports, eight-entry FIFO.
`timescale 1ns/1ps
module tb_pio_poll_sequencer;
  localparam int NP    = 4;
  localparam int PER   = 16;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        m_address;
  logic [32*NP-1:0]  m_readdata;
  logic [2:0]        s_address = '0;
  logic              s_read = 1'b0;
  logic              s_write = 1'b0;
  logic [31:0]       s_writedata = '0;
  logic [31:0]       s_readdata;
  logic              irq;
  logic [31:0]       port [NP];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cyc = 0;
  logic [31:0] rd;

  pio_poll_sequencer #(.NUM_PORTS(NP), .PERIOD(PER), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .m_address(m_address), .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NP; i++) m_readdata[32*i +: 32] = port[i];
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    step(1);
    s_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
    s_address = a; s_read = 1'b1;
    step(1);
    s_read = 1'b0;
    d = s_readdata;
  endtask

  // Sweeps capture at offsets 3..12 of each PER-cycle frame after enable.
  task automatic align();
    while (((cyc - en_cyc) % PER) != 0) step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NP; i++) port[i] = '0;
    step(3);
    check("rst_maddr", {30'd0, m_address}, 32'd0);
    check("rst_rdata", s_readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    step(1);
    cpu_read(3'd1, rd); check("rst_status", rd, 32'h0);
    cpu_read(3'd2, rd); check("rst_ctrl", rd, 32'h0);
    cpu_read(3'd3, rd); check("rst_mask", rd, 32'hF);
    cpu_read(3'd4, rd); check("rst_tstamp", rd, 32'h0);
    cpu_read(3'd0, rd); check("empty_data", rd, 32'h0);

    // Priming: two sweeps with unchanged inputs push nothing.
    cpu_write(3'd2, 32'h1);
    en_cyc = cyc;
    step(48);
    cpu_read(3'd1, rd); check("prime_status", rd, 32'h0);
    check("prime_irq", {31'd0, irq}, 32'd0);

    cpu_write(3'd2, 32'h3);
    align();
    port[2] = 32'hDEADBEEF;
    step(16);
    check("chg_irq", {31'd0, irq}, 32'd1);
    cpu_read(3'd1, rd); check("chg_status", rd, 32'h0200_0001);
`ifndef PIO_POLL_TIMESTAMP_EN
    cpu_read(3'd4, rd); check("chg_tstamp_off", rd, 32'h0);
`endif
    cpu_read(3'd0, rd); check("chg_data", rd, 32'hDEADBEEF);
    cpu_read(3'd1, rd); check("chg_status_pop", rd, 32'h0);
    check("chg_irq_fall", {31'd0, irq}, 32'd0);

    cpu_write(3'd3, 32'hB);
    cpu_read(3'd3, rd); check("mask_rd", rd, 32'hB);
    align();
    port[2] = 32'h1111_1111;
    port[3] = 32'h3333_3333;
    step(16);
    cpu_read(3'd1, rd); check("mask_status", rd, 32'h0300_0001);
    cpu_read(3'd0, rd); check("mask_data", rd, 32'h3333_3333);
    cpu_read(3'd1, rd); check("mask_status_pop", rd, 32'h0);

    // Nine toggles of port0 into an eight-entry FIFO.
    align();
    for (int j = 0; j < 9; j++) begin
      port[0] = (j % 2 == 0) ? 32'hA5A5_A5A5 : 32'h0;
      step(16);
    end
    cpu_read(3'd1, rd); check("ovf_status", rd, 32'h8000_0008);
    check("ovf_irq", {31'd0, irq}, 32'd1);
    cpu_write(3'd2, 32'h7);
    cpu_read(3'd1, rd); check("ovf_clr_status", rd, 32'h0000_0008);
    cpu_read(3'd2, rd); check("ovf_clr_ctrl", rd, 32'h3);
    for (int j = 0; j < 8; j++) begin
      cpu_read(3'd0, rd);
      check($sformatf("ovf_drain%0d", j), rd, (j % 2 == 0) ? 32'hA5A5_A5A5 : 32'h0);
    end
    cpu_read(3'd1, rd); check("ovf_drained", rd, 32'h0);

    // Three entries, then a pop landing on the port3 capture edge.
    align();
    port[0] = 32'h10; port[1] = 32'h11; port[3] = 32'h13;
    step(16);
    port[3] = 32'h23;
    step(11);
    cpu_read(3'd0, rd); check("pp_pop", rd, 32'h10);
    cpu_read(3'd1, rd); check("pp_status", rd, 32'h0100_0003);
    cpu_read(3'd0, rd); check("pp_d1", rd, 32'h11);
    cpu_read(3'd0, rd); check("pp_d2", rd, 32'h13);
    cpu_read(3'd0, rd); check("pp_d3", rd, 32'h23);
    cpu_read(3'd1, rd); check("pp_empty", rd, 32'h0);

    cpu_write(3'd6, 32'hFFFF_FFFF);
    cpu_read(3'd6, rd); check("unused6", rd, 32'h0);
    cpu_read(3'd7, rd); check("unused7", rd, 32'h0);

    // Asynchronous reset while a capture with a pending push is in progress.
    align();
    port[1] = 32'h55;
    step(16);
    port[0] = 32'h77;
    cpu_read(3'd1, rd); check("rst2_pre_status", rd, 32'h0100_0001);
    step(1);
    check("rst2_pre_irq", {31'd0, irq}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst2_irq", {31'd0, irq}, 32'd0);
    check("rst2_rdata", s_readdata, 32'd0);
    check("rst2_maddr", {30'd0, m_address}, 32'd0);
    step(3);
    reset_n = 1'b1;
    step(1);
    cpu_read(3'd1, rd); check("rst2_status", rd, 32'h0);
    cpu_read(3'd2, rd); check("rst2_ctrl", rd, 32'h0);
    cpu_read(3'd3, rd); check("rst2_mask", rd, 32'hF);
    cpu_read(3'd4, rd); check("rst2_tstamp", rd, 32'h0);
    cpu_read(3'd0, rd); check("rst2_data", rd, 32'h0);
    check("rst2_irq_after", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
